// File: rtl/seg7_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// seg7_scan_controller_pkg - segment codes, FSM encoding and counter sizing
// Rev 1.0
// ============================================================================
package seg7_scan_controller_pkg;

  // Active-high segments, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Entry [n] is the glyph for nibble n: 0-9, then A b C d E F
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b111_0001, 7'b111_1001, 7'b101_1110, 7'b011_1001,
    7'b111_1100, 7'b111_0111, 7'b110_1111, 7'b111_1111,
    7'b000_0111, 7'b111_1101, 7'b110_1101, 7'b110_0110,
    7'b100_1111, 7'b101_1011, 7'b000_0110, 7'b011_1111
  };

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHOW_ENC  = 2'd1;
  localparam logic [1:0] ST_BLANK_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHOW  = ST_SHOW_ENC,
    ST_BLANK = ST_BLANK_ENC
  } state_e;

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_controller_bcd7seg.sv
`default_nettype none
// ============================================================================
// seg7_scan_controller_bcd7seg - BCD7Segment decoder, hex nibble to gfedcba
// Rev 1.0
// ============================================================================
module seg7_scan_controller_bcd7seg
  import seg7_scan_controller_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[bcd_i];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// seg7_scan_controller - multiplexed 7-seg scan with blanking, LZ suppression
// and frame-aligned load handshake.  Rev 1.0
// ============================================================================
module seg7_scan_controller
  import seg7_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    update_done
);

  localparam int              CW        = cnt_width(REFRESH_DIV);
  localparam int              IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0]     ON_CYCLES = 32'(REFRESH_DIV - BLANK_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [6:0]              segment_q, segment_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    done_q, done_d;

  logic                    boundary;
  logic                    apply;
  logic [3:0]              nibble;
  logic                    suppress;
  logic [6:0]              dec_seg;

  // The slot counter spans the whole slot; the on/blank split is a threshold.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SHOW;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = ST_SHOW;
      cnt_d   = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d   = cnt_q + CW'(1);
      state_d = ((32'(cnt_q) + 32'd1) < ON_CYCLES) ? ST_SHOW : ST_BLANK;
    end
  end

  // While dark every cycle acts as a frame boundary so loads land at once.
  assign apply = (state_q == ST_IDLE) || boundary;

  always_comb begin
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    done_d      = 1'b0;
    if (apply && load) begin
      disp_val_d  = value;
      disp_dp_d   = dp_in;
      pend_flag_d = 1'b0;
      done_d      = 1'b1;
    end else if (apply && pend_flag_q) begin
      disp_val_d  = pend_val_q;
      disp_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
      done_d      = 1'b1;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // Outputs are computed from next-state values so they line up with state_q.
  always_comb begin
    nibble   = disp_val_d[3:0];
    suppress = lz_suppress && (idx_d != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nibble = disp_val_d[4*k +: 4];
      end
      if ((IW'(k) >= idx_d) && (disp_val_d[4*k +: 4] != 4'd0)) begin
        suppress = 1'b0;
      end
    end
  end

  seg7_scan_controller_bcd7seg u_dec (
    .bcd_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    segment_d  = SEG_BLANK;
    dp_d       = 1'b0;
    digit_en_d = '0;
    if (state_d == ST_SHOW) begin
      segment_d  = suppress ? SEG_BLANK : dec_seg;
      dp_d       = disp_dp_d[idx_d];
      digit_en_d = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      segment_q   <= SEG_BLANK;
      dp_q        <= 1'b0;
      digit_en_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      segment_q   <= segment_d;
      dp_q        <= dp_d;
      digit_en_q  <= digit_en_d;
      done_q      <= done_d;
    end
  end

  assign segment     = segment_q;
  assign dp          = dp_q;
  assign digit_en    = digit_en_q;
  assign update_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_controller - scoreboard bench: 4 digits, 8-cycle slots, 2 blank
// Rev 1.0
// ============================================================================
module tb_seg7_scan_controller;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  digit_en;
  logic        update_done;

  seg7_scan_controller #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .segment     (segment),
    .dp          (dp),
    .digit_en    (digit_en),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  en;
    logic [6:0]  seg;
    logic        dp;
    logic        done;
    logic        chk_done;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [31:0] cyc = 32'd0;

  // Reference view of the display: frame position and what should be shown
  logic        run = 1'b0;
  int          pos = 0;
  logic [15:0] shown_val = 16'h0;
  logic [3:0]  shown_dp = 4'h0;
  logic        have_next = 1'b0;
  logic [15:0] next_val = 16'h0;
  logic [3:0]  next_dp = 4'h0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b0111111;  4'h1: r = 7'b0000110;
      4'h2: r = 7'b1011011;  4'h3: r = 7'b1001111;
      4'h4: r = 7'b1100110;  4'h5: r = 7'b1101101;
      4'h6: r = 7'b1111101;  4'h7: r = 7'b0000111;
      4'h8: r = 7'b1111111;  4'h9: r = 7'b1101111;
      4'hA: r = 7'b1110111;  4'hB: r = 7'b1111100;
      4'hC: r = 7'b0111001;  4'hD: r = 7'b1011110;
      4'hE: r = 7'b1111001;  default: r = 7'b1110001;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (update_done === 1'b1) done_cnt++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_mon = sb.pop_front();
      total++;
      if (e_mon.cyc != cyc || digit_en !== e_mon.en || segment !== e_mon.seg ||
          dp !== e_mon.dp || (e_mon.chk_done && update_done !== e_mon.done)) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d: got en=%b seg=%b dp=%b done=%b, want en=%b seg=%b dp=%b done=%b (for cyc %0d)",
                 cyc, digit_en, segment, dp, update_done,
                 e_mon.en, e_mon.seg, e_mon.dp, e_mon.done, e_mon.cyc);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic tick(input logic en_i, input logic ld_i, input logic [15:0] v_i,
                      input logic [3:0] d_i, input logic lz_i);
    exp_t e;
    @(posedge clk);
    #1;
    enable      = en_i;
    load        = ld_i;
    value       = v_i;
    dp_in       = d_i;
    lz_suppress = lz_i;
    e     = '0;
    e.cyc = cyc + 32'd1;
    if (!en_i) begin
      run = 1'b0;
      pos = 0;
    end else begin
      e.chk_done = 1'b1;
      if (!run) begin
        run = 1'b1;
        pos = 0;
      end else begin
        pos = (pos + 1) % FRAME;
        if (pos == 0) begin
          if (ld_i) begin
            shown_val = v_i;
            shown_dp  = d_i;
            e.done    = 1'b1;
          end else if (have_next) begin
            shown_val = next_val;
            shown_dp  = next_dp;
            e.done    = 1'b1;
          end
          have_next = 1'b0;
        end else if (ld_i) begin
          next_val  = v_i;
          next_dp   = d_i;
          have_next = 1'b1;
        end
      end
      if ((pos % RD) < (RD - BC)) begin
        int d = pos / RD;
        e.en  = 4'b0001 << d;
        e.dp  = shown_dp[d];
        e.seg = (lz_i && d > 0 && (shown_val >> (4 * d)) == 16'h0) ? 7'b0000000
                                                                   : seg_of(shown_val[4*d +: 4]);
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_until(input int target, input logic lz_i);
    int guard = 0;
    while (pos != target && guard < 2 * FRAME) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0, lz_i);
      guard++;
    end
  endtask

  task automatic test_reset();
    #7;
    total++;
    if ({digit_en, segment, dp, update_done} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", {digit_en, segment, dp, update_done}, 13'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_idle_load();
    int d0 = done_cnt;
    tick(1'b0, 1'b1, 16'h12A0, 4'b0000, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL idle_load_done got=%0d want=1", done_cnt - d0);
    end
    shown_val = 16'h12A0;
    shown_dp  = 4'b0000;
    have_next = 1'b0;
    repeat (2 * FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_lz_suppress();
    int d0 = done_cnt;
    run_until(5, 1'b1);
    tick(1'b1, 1'b1, 16'h0042, 4'b1001, 1'b1);
    repeat (2 * FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    tick(1'b1, 1'b1, 16'h0000, 4'b0000, 1'b1);
    repeat (2 * FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    repeat (FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    total++;
    if (done_cnt - d0 != 2) begin
      bad++;
      $display("FAIL lz_done_count got=%0d want=2", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    run_until(3, 1'b0);
    tick(1'b1, 1'b1, 16'h1111, 4'b0010, 1'b0);
    repeat (5) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    tick(1'b1, 1'b1, 16'h2222, 4'b0100, 1'b0);
    repeat (2 * FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL back_to_back_done got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_boundary_load();
    int d0 = done_cnt;
    run_until(10, 1'b0);
    tick(1'b1, 1'b1, 16'h3333, 4'b1111, 1'b0);
    run_until(FRAME - 1, 1'b0);
    tick(1'b1, 1'b1, 16'h9999, 4'b0001, 1'b0);
    repeat (2 * FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL boundary_load_done got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_enable_drop();
    run_until(2 * RD + 3, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    repeat (FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_async_reset();
    run_until(3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    total++;
    if (digit_en !== 4'b0001) begin
      bad++;
      $display("FAIL pre_reset_digit_en got=%b want=%b", digit_en, 4'b0001);
    end
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    total++;
    if ({digit_en, segment, dp, update_done} !== 13'b0) begin
      bad++;
      $display("FAIL async_reset_outputs got=%b want=%b", {digit_en, segment, dp, update_done}, 13'b0);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    run       = 1'b0;
    pos       = 0;
    shown_val = 16'h0;
    shown_dp  = 4'h0;
    have_next = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    repeat (FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_lz_suppress();
    test_back_to_back();
    test_boundary_load();
    test_enable_drop();
    test_async_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexed scan controller for a common-bus multi-digit 7-segment display. It owns a single BCD7Segment decoder and shares it across NUM_DIGITS digit positions, one position at a time. It adds inter-digit blanking for anti-ghosting, optional leading-zero suppression, and a tear-free load handshake that applies new values only at frame boundaries. It sits between the value-producing datapath (counters, ALU result registers) and the board display pins.

## Interface
- NUM_DIGITS, 4: number of digit positions, 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, ≥2.
- BLANK_CYCLES, 500: cycles per slot with all digits off, 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 0 forces the display dark.
- load  in  1  one-cycle request to latch `value` and `dp_in`.
- value  in  4*NUM_DIGITS  nibble k = BCD/hex for digit k; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, active high.
- lz_suppress  in  1  level; 1 blanks leading zero digits.
- segment  out  7  active-high segments, bit order gfedcba, registered.
- dp  out  1  decimal point for the active digit, registered.
- digit_en  out  NUM_DIGITS  one-hot active-high digit select, or all 0; registered.
- update_done  out  1  one-cycle pulse when a load has reached the display register.

## Operation
- Registers: pend_val/pend_dp with pend_flag; disp_val/disp_dp; digit index idx; slot counter cnt.
- FSM states:
  - IDLE: all outputs 0, idx=0, cnt=0.
  - SHOW: digit idx driven for REFRESH_DIV−BLANK_CYCLES cycles.
  - BLANK: digit_en=0, segment=0, dp=0 for BLANK_CYCLES cycles.
- Transitions:
  - IDLE→SHOW(idx 0) on an edge with enable=1.
  - SHOW→BLANK at end of the on-time. When BLANK_CYCLES=0, go directly to SHOW(idx+1).
  - BLANK→SHOW(idx+1 mod NUM_DIGITS).
  - Any state→IDLE on an edge with enable=0.
- Frame boundary: the last cycle of the final slot for digit NUM_DIGITS−1, i.e. the cycle before idx wraps to 0.
- In SHOW:
  - segment = decoder(disp_val nibble idx). 0–9 map to digits; 10–15 map to A, b, C, d, E, F.
  - dp = disp_dp[idx].
  - digit_en = 1<<idx.
- Leading-zero suppression: when lz_suppress=1, digit k>0 is suppressed if nibbles k..NUM_DIGITS−1 are all 0. A suppressed digit has segment=0 but keeps digit_en and dp. Digit 0 is never suppressed.
- Load handshake:
  - load=1 captures value/dp_in into pend_* and sets pend_flag.
  - A later load before the boundary overwrites pend_* (last wins).
  - At a frame boundary:
    - If load=1 in that same cycle, disp_* takes the live `value`/`dp_in` directly.
    - Else if pend_flag=1, disp_* takes pend_*.
    - In either case pend_flag clears and update_done pulses on the following cycle.
- In IDLE, loads apply on the next edge, with update_done one cycle later. This makes loads possible while the display is dark.
- disp_* survives enable=0. Only reset clears it.

## Timing
- Reset (async assert): state=IDLE, segment=0, dp=0, digit_en=0, update_done=0, disp_*=0, pend_*=0, pend_flag=0, idx=0, cnt=0. Deassertion is synchronous to the next clk edge.
- Outputs are registered in lockstep with the state. The first edge with enable=1 makes digit_en=1, showing digit 0 in that cycle.
- A change to value/lz_suppress during SHOW takes effect on the next registered cycle. disp_val changes only at a boundary, so there is no intra-frame tearing.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- enable falling mid-slot: outputs are 0 after the next edge. Re-enable restarts at digit 0, cnt=0.

## Structure
- Shared package holds:
  - the 7-bit segment codes for 0–F and blank (7'b000_0000);
  - the FSM state encoding localparams (IDLE, SHOW, BLANK);
  - the slot-counter width function (clog2 of REFRESH_DIV).
- One sub-module: BCD7Segment, instantiated once. The controller drives its BCD input from the idx mux and registers its output after suppression gating.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, enable=1, load 16'h12A0 while IDLE → update_done pulses. Each frame then shows, for 6 cycles on / 2 cycles off each:
   - digit_en 0001 with segment 0111111;
   - 0010 with 1110111;
   - 0100 with 1011011;
   - 1000 with 0000110.
2. lz_suppress=1, value 16'h0042 → digits 3 and 2 show segment 0000000 with digit_en asserted; digit 1 shows 1100110; digit 0 shows 1011011. With 16'h0000, digit 0 shows 0111111.
3. Two loads mid-frame (16'h1111 then 16'h2222) → displayed value is unchanged until the boundary. Next frame shows 2222. Exactly one update_done pulse occurs, one cycle after the boundary.
4. Load 16'h9999 exactly in the boundary cycle while pend_flag holds 16'h3333 → next frame shows 9999; one update_done pulse.
5. enable→0 at cycle 3 of digit 2 → all outputs 0 after the next edge. enable→1 → digit 0 reappears showing the retained value.
6. reset_n asserted mid-SHOW, asynchronously between edges → outputs 0 immediately, before the next edge. Release → IDLE; disp cleared to 0.
